// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - per-key synchroniser, debouncer and press/release pulse generator
// Optional feature macro: KEY_AUTOREPEAT_EN (adds held-key auto-repeat press pulses)
module key_debounce_pulse #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic                ADC_CLK_10,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity check; also keeps the repeat parameters referenced in every build.
  if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debounce_pulse: all parameters must be >= 1");
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W     = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST  = RPT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             sync1;
    logic             sk;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [RPT_W-1:0] rcnt_q;
    logic [RPT_W-1:0] rcnt_d;
    logic             rpt_q;    // 0: waiting out the initial delay, 1: in periodic repeat phase
    logic             rpt_d;
`endif

    // Two-flop synchroniser for the asynchronous key pin; resets to the released level.
    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= 1'b1;
        sk    <= 1'b1;
      end else begin
        sync1 <= key_n[i];
        sk    <= sync1;
      end
    end

    // Debounce state, counter and registered outputs.
    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q    <= '0;
        rpt_q     <= 1'b0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q    <= rcnt_d;
        rpt_q     <= rpt_d;
`endif
      end
    end

    // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_d    = rcnt_q;
      rpt_d     = rpt_q;
`endif
      case (state_q)
        IDLE: begin
          if (!sk) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sk) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (sk) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sk) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
`ifdef KEY_AUTOREPEAT_EN
      // Repeat timer runs across release bounces; an accepted release wins over a repeat hit.
      if (press_d) begin
        rcnt_d = '0;
        rpt_d  = 1'b0;
      end else if (release_d) begin
        rcnt_d = '0;
        rpt_d  = 1'b0;
      end else if (level_q && (state_q == PRESSED || state_q == RELEASE_WAIT)) begin
        if (rcnt_q == (rpt_q ? PER_LAST : DLY_LAST)) begin
          press_d = 1'b1;
          rcnt_d  = '0;
          rpt_d   = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
`endif
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - directed self-checking bench for key_debounce_pulse
module tb_key_debounce_pulse;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] key_n;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int vectors = 0;
  int errors  = 0;

  key_debounce_pulse #(
    .NUM_KEYS        (2),
    .DEBOUNCE_CYCLES (2),
    .REPEAT_DELAY    (4),
    .REPEAT_PERIOD   (3)
  ) dut (
    .ADC_CLK_10  (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_n   = 2'b00;
    settle(2);
    vectors++;
    if (key_level !== 2'b00) begin errors++; $display("FAIL reset_level: got %b want 00", key_level); end
    vectors++;
    if (key_press !== 2'b00) begin errors++; $display("FAIL reset_press: got %b want 00", key_press); end
    vectors++;
    if (key_release !== 2'b00) begin errors++; $display("FAIL reset_release: got %b want 00", key_release); end
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      vectors++;
      if (key_press !== ((e == 5) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL held_after_reset_press e%0d: got %b want %b", e, key_press, (e == 5) ? 2'b11 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL held_after_reset_level e%0d: got %b want %b", e, key_level, (e >= 5) ? 2'b11 : 2'b00);
      end
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({key_level, key_press, key_release} !== 6'b0) begin
      errors++; $display("FAIL async_reset_pressed: got %b want 000000", {key_level, key_press, key_release});
    end
    key_n = 2'b11;
    settle(3);
    reset_n = 1'b1;
    settle(3);
  endtask

  task automatic test_single_key();
    logic [1:0] ep;
    key_n = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      step();
      vectors++;
      if (key_press !== ((e == 5) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL single_press e%0d: got %b want %b", e, key_press, (e == 5) ? 2'b10 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL single_level e%0d: got %b want %b", e, key_level, (e >= 5) ? 2'b10 : 2'b00);
      end
    end
    key_n = 2'b11;
    for (int r = 1; r <= 6; r++) begin
      step();
      ep = (AR && (r == 1 || r == 4)) ? 2'b10 : 2'b00;
      vectors++;
      if (key_press !== ep) begin errors++; $display("FAIL single_rel_press r%0d: got %b want %b", r, key_press, ep); end
      vectors++;
      if (key_release !== ((r == 5) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL single_release r%0d: got %b want %b", r, key_release, (r == 5) ? 2'b10 : 2'b00);
      end
      vectors++;
      if (key_level !== ((r < 5) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL single_rel_level r%0d: got %b want %b", r, key_level, (r < 5) ? 2'b10 : 2'b00);
      end
    end
  endtask

  task automatic test_glitch();
    key_n = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 2) key_n = 2'b11;
      vectors++;
      if ({key_level, key_press, key_release} !== 6'b0) begin
        errors++; $display("FAIL glitch_2cyc e%0d: got %b want 000000", e, {key_level, key_press, key_release});
      end
    end
    key_n = 2'b10;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 3) key_n = 2'b11;
      vectors++;
      if (key_press !== ((e == 5) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL min_press e%0d: got %b want %b", e, key_press, (e == 5) ? 2'b01 : 2'b00);
      end
      vectors++;
      if (key_release !== ((e == 8) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL min_release e%0d: got %b want %b", e, key_release, (e == 8) ? 2'b01 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5 && e <= 7) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL min_level e%0d: got %b want %b", e, key_level, (e >= 5 && e <= 7) ? 2'b01 : 2'b00);
      end
    end
    settle(3);
  endtask

  task automatic test_release_bounce();
    logic [1:0] ep;
    key_n = 2'b01;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 5) key_n = 2'b11;
      if (e == 7) key_n = 2'b01;
      if (e == 8) key_n = 2'b11;
      ep = (e == 5 || (AR && (e == 9 || e == 12))) ? 2'b10 : 2'b00;
      vectors++;
      if (key_press !== ep) begin errors++; $display("FAIL bounce_press e%0d: got %b want %b", e, key_press, ep); end
      vectors++;
      if (key_release !== ((e == 13) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL bounce_release e%0d: got %b want %b", e, key_release, (e == 13) ? 2'b10 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5 && e <= 12) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL bounce_level e%0d: got %b want %b", e, key_level, (e >= 5 && e <= 12) ? 2'b10 : 2'b00);
      end
    end
  endtask

  task automatic test_reset_midway();
    key_n = 2'b10;
    settle(3);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({key_level, key_press, key_release} !== 6'b0) begin
      errors++; $display("FAIL async_reset_press_wait: got %b want 000000", {key_level, key_press, key_release});
    end
    settle(2);
    vectors++;
    if ({key_level, key_press, key_release} !== 6'b0) begin
      errors++; $display("FAIL held_in_reset: got %b want 000000", {key_level, key_press, key_release});
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      vectors++;
      if (key_press !== ((e == 5) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL redebounce_press e%0d: got %b want %b", e, key_press, (e == 5) ? 2'b01 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL redebounce_level e%0d: got %b want %b", e, key_level, (e >= 5) ? 2'b01 : 2'b00);
      end
    end
    key_n = 2'b11;
    settle(10);
  endtask

  task automatic test_autorepeat();
    logic [1:0] ep;
    key_n = 2'b01;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 20) key_n = 2'b11;
      ep = (e == 5 || (AR && (e == 9 || e == 12 || e == 15 || e == 18 || e == 21 || e == 24))) ? 2'b10 : 2'b00;
      vectors++;
      if (key_press !== ep) begin errors++; $display("FAIL repeat_press e%0d: got %b want %b", e, key_press, ep); end
      vectors++;
      if (key_release !== ((e == 25) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL repeat_release e%0d: got %b want %b", e, key_release, (e == 25) ? 2'b10 : 2'b00);
      end
      vectors++;
      if (key_level !== ((e >= 5 && e <= 24) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL repeat_level e%0d: got %b want %b", e, key_level, (e >= 5 && e <= 24) ? 2'b10 : 2'b00);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 2'b11;
    test_reset();
    test_single_key();
    test_glitch();
    test_release_bounce();
    test_reset_midway();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
